// File: rtl/ctrl_encode_def.sv
// Shared encodings for the fetch unit and the control decoder.
//   NPC_*       : next-PC select codes driven by control on NPCOp
//   RESET_PC_DEF: default boot address
//   fetch_state_e: fetch FSM state encoding
package ctrl_encode_def;

  localparam logic [3:0] NPC_PLUS4  = 4'd0;
  localparam logic [3:0] NPC_BRANCH = 4'd1;
  localparam logic [3:0] NPC_JUMP   = 4'd2;
  localparam logic [3:0] NPC_JR     = 4'd3;
  localparam logic [3:0] NPC_JALR   = 4'd4;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC computation.
//   pc, npc_op, imm32, imm26, rs_data -> next_pc, pc_plus4, misaligned
// misaligned flags a next_pc whose low two bits are not zero.
module npc_calc
  import ctrl_encode_def::*;
(
  input  logic [31:0] pc,
  input  logic [3:0]  npc_op,
  input  logic [31:0] imm32,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_data,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4,
  output logic        misaligned
);

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    case (npc_op)
      NPC_BRANCH: next_pc = pc_plus4 + {imm32[29:0], 2'b00};
      NPC_JUMP:   next_pc = {pc_plus4[31:28], imm26, 2'b00};
      NPC_JR,
      NPC_JALR:   next_pc = rs_data;
      default:    next_pc = pc_plus4;
    endcase
  end

  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one imem request at a time,
// holds the fetched word for decode and computes the next PC on retire.
//   clk, rst                 : clock, async active-high reset
//   imem_req/addr/ack/rdata  : instruction memory handshake
//   instr/instr_valid/pc/pc_plus4, instr_ready : decode handshake
//   NPCOp, imm32, imm26, rs_data : next-PC operands, sampled on retire
//   fetch_err                : sticky timeout / misaligned-target flag
module ifu_fetch
  import ctrl_encode_def::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
  parameter int          TIMEOUT_CYC = 16,
  parameter int          CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [3:0]  NPCOp,
  input  logic [31:0] imm32,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_data,
  output logic        fetch_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] next_pc;
  logic        next_misaligned;

  npc_calc u_npc (
    .pc         (pc_q),
    .npc_op     (NPCOp),
    .imm32      (imm32),
    .imm26      (imm26),
    .rs_data    (rs_data),
    .next_pc    (next_pc),
    .pc_plus4   (pc_plus4),
    .misaligned (next_misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          cnt_d   = '0;
          state_d = ST_VALID;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_HALT;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_VALID: begin
        if (instr_ready) begin
          // PC takes the bad target too so the fault address is visible
          pc_d = next_pc;
          if (next_misaligned) begin
            err_d   = 1'b1;
            state_d = ST_HALT;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  // Handshake outputs decode from state so reset drops imem_req at once.
  always_comb begin
    imem_req    = (state_q == ST_FETCH);
    instr_valid = (state_q == ST_VALID);
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign fetch_err = err_q;

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit sitting directly upstream of the main decoder/control block.
- Owns the PC register and drives a variable-latency instruction memory through a req/ack handshake.
- Presents the fetched instruction (opcode and funct fields included) with a valid/ready handshake.
- Consumes the decoder's NPCOp, plus immediate/jump/register operands, at the moment of acceptance to compute the next PC.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded at reset; first fetch address.
- TIMEOUT_CYC, 16, max cycles to wait for imem_ack before raising fetch_err.
- CNT_W, 5, width of the timeout counter; must hold TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; held high until acked.
- imem_addr  out  32  word-aligned fetch address; stable while imem_req=1.
- imem_ack  in  1  one-cycle pulse; imem_rdata valid in the same cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  registered instruction for decode.
- instr_valid  out  1  instr is valid.
- instr_ready  in  1  decode/execute accepts instr this cycle (retire).
- pc  out  32  address of instr.
- pc_plus4  out  32  pc+4, used for jal/jalr link.
- NPCOp  in  4  next-PC select from control, sampled only when instr_valid & instr_ready.
- imm32  in  32  sign-extended 16-bit immediate for branches.
- imm26  in  26  jump target field.
- rs_data  in  32  register value for jr/jalr.
- fetch_err  out  1  sticky: fetch timeout or misaligned target.

Behaviour:
- Reset is asynchronous and active-high on rst; a single clock, clk.
- Reset values: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_err=0, timeout counter=0, state=BOOT.
- FSM states: BOOT, FETCH, VALID, HALT.
- BOOT: lasts exactly one cycle after reset release. Next cycle goes to FETCH with imem_req=1 and imem_addr=pc.
- FETCH:
  - imem_req=1 and imem_addr=pc, held constant.
  - On imem_ack: instr<=imem_rdata, instr_valid<=1, imem_req<=0, go to VALID. Counter clears.
  - Without ack: counter increments. When the counter reaches TIMEOUT_CYC-1 with no ack: fetch_err<=1, imem_req<=0, go to HALT.
- VALID:
  - instr, pc, and instr_valid are held while instr_ready=0.
  - On instr_ready=1, next PC is computed from NPCOp:
    - 0: pc+4.
    - 1 (branch): pc+4 + (imm32<<2), 32-bit wrap.
    - 2 (jump): {pc_plus4[31:28], imm26, 2'b00}.
    - 3 (jr): rs_data.
    - 4 (jalr): rs_data.
    - any other code: pc+4.
  - pc<=next, instr_valid<=0, go to FETCH. The request is issued the cycle after acceptance.
  - Acceptance-to-next-request latency is 1 cycle. Minimum throughput is one instruction per 3 cycles with a 1-cycle-ack memory.
  - If the computed next PC has bits [1:0] != 0: fetch_err<=1, pc<=next (for debug visibility), go to HALT.
- HALT:
  - imem_req=0, instr_valid=0, and the block stays in HALT until rst.
- pc_plus4 = pc+4 combinationally; wraps from 32'hFFFF_FFFC to 0 with no error.
- imem_ack while not in FETCH is ignored, and no state changes as a result.
- instr_ready while instr_valid=0 is ignored.
- Reset asserted mid-fetch (imem_req=1): req drops immediately (asynchronously). Any later ack for the aborted request arrives outside FETCH and is therefore ignored. Memory-side cancellation is the memory's responsibility.
- No speculation and no fetch-ahead: at most one request outstanding.

Decomposition:
- Shared package, ctrl_encode_def: NPC encodings NPC_PLUS4=0, NPC_BRANCH=1, NPC_JUMP=2, NPC_JR=3, NPC_JALR=4; RESET_PC default; FSM state encodings.
- The control decoder uses the same NPC encodings from this package.
- One sub-module: npc_calc, purely combinational (pc, NPCOp, imm32, imm26, rs_data -> next_pc, misaligned). Shared with any future pipelined variant.

Test Plan:
- Reset then ack with 1-cycle latency, rdata=32'h2008_0005, ready=1 -> first imem_addr=32'h0000_3000; instr_valid next cycle; second imem_addr=32'h0000_3004.
- Branch: pc=32'h0000_3008, NPCOp=1, imm32=32'hFFFF_FFFE, accepted -> next imem_addr=32'h0000_3004.
- Jump and jr:
  - pc=32'h0000_3010, NPCOp=2, imm26=26'h0000C10 -> imem_addr=32'h0000_3040.
  - NPCOp=3, rs_data=32'h0000_3100 -> imem_addr=32'h0000_3100.
- Back-pressure: instr_ready=0 for 5 cycles -> instr, pc, and instr_valid constant; imem_req=0 throughout; stray imem_ack pulse ignored.
- Errors:
  - No ack for TIMEOUT_CYC=16 cycles -> fetch_err=1, imem_req=0, state HALT.
  - Separately, jr with rs_data=32'h0000_3002 -> fetch_err=1, no further requests.
- Reset mid-fetch: rst pulsed while imem_req=1, late ack arrives during BOOT -> ignored; fetch restarts at 32'h0000_3000; fetch_err=0.
